sigbin_serial_ctrl: RTL and testbench



---
 rtl/sigbin_pkg.sv | 15 +
 rtl/sigbin_slice.sv | 25 ++
 rtl/sigbin_serial_ctrl.sv | 132 +++++++++++++
 tb/tb_sigbin_serial_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sigbin_pkg.sv
// Shared opcodes and FSM encoding for the bit-serial ALU sequencer.
package sigbin_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_OR  = 2'b11;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

endpackage

// File: rtl/sigbin_slice.sv
// One-bit ALU slice: full adder for ADD/SUB, plain gates for AND/OR.
module sigbin_slice
  import sigbin_pkg::*;
(
  input  logic [1:0] i_x,
  input  logic [1:0] i_s,
  input  logic       i_cin,
  output logic       o_r,
  output logic       o_cout
);

  always_comb begin
    o_r    = 1'b0;
    o_cout = 1'b0;
    unique case (i_s)
      OP_ADD, OP_SUB: begin
        o_r    = i_x[0] ^ i_x[1] ^ i_cin;
        o_cout = (i_x[0] & i_x[1]) | (i_x[0] & i_cin) | (i_x[1] & i_cin);
      end
      OP_AND: o_r = i_x[0] & i_x[1];
      OP_OR:  o_r = i_x[0] | i_x[1];
    endcase
  end

endmodule

// File: rtl/sigbin_serial_ctrl.sv
// Bit-serial sequencer: walks a WIDTH-bit ADD/SUB/AND/OR through one 1-bit slice,
// LSB first, with a start/busy/done handshake.
module sigbin_serial_ctrl
  import sigbin_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_zero
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e           r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic             r_carry, w_carry_d;
  logic [1:0]       r_op, w_op_d;
  logic [WIDTH-1:0] r_a_sh, w_a_sh_d;
  logic [WIDTH-1:0] r_b_sh, w_b_sh_d;
  logic [WIDTH-2:0] r_acc, w_acc_d;
  logic [WIDTH-1:0] r_result, w_result_d;
  logic             r_cout, w_cout_d;
  logic             r_zero, w_zero_d;
  logic             r_busy, r_done;

  logic             w_accept;
  logic             w_slice_b;
  logic             w_slice_r;
  logic             w_slice_cout;
  logic [WIDTH-1:0] w_full;

  // SUB runs as a + ~b + 1: invert b here, the +1 comes from the preset carry.
  assign w_slice_b = r_b_sh[0] ^ (r_op == OP_SUB);
  // Accumulator keeps WIDTH-1 bits; the live slice bit completes the word.
  assign w_full    = {w_slice_r, r_acc};
  assign w_accept  = i_start && (r_state == StIdle || r_state == StDone);

  sigbin_slice u_slice (
    .i_x    ({w_slice_b, r_a_sh[0]}),
    .i_s    (r_op),
    .i_cin  (r_carry),
    .o_r    (w_slice_r),
    .o_cout (w_slice_cout)
  );

  always_comb begin
    w_state_d  = r_state;
    w_cnt_d    = r_cnt;
    w_carry_d  = r_carry;
    w_op_d     = r_op;
    w_a_sh_d   = r_a_sh;
    w_b_sh_d   = r_b_sh;
    w_acc_d    = r_acc;
    w_result_d = r_result;
    w_cout_d   = r_cout;
    w_zero_d   = r_zero;

    unique case (r_state)
      StIdle: w_state_d = i_start ? StRun : StIdle;
      StRun: begin
        w_acc_d   = w_full[WIDTH-1:1];
        w_carry_d = w_slice_cout;
        w_a_sh_d  = r_a_sh >> 1;
        w_b_sh_d  = r_b_sh >> 1;
        w_cnt_d   = r_cnt + CntW'(1);
        if (r_cnt == LastCnt) begin
          w_state_d  = StDone;
          w_result_d = w_full;
          w_cout_d   = w_slice_cout;
          w_zero_d   = (w_full == '0);
        end
      end
      StDone:  w_state_d = i_start ? StRun : StIdle;
      default: w_state_d = StIdle;
    endcase

    if (w_accept) begin
      w_op_d    = i_op;
      w_a_sh_d  = i_a;
      w_b_sh_d  = i_b;
      w_cnt_d   = '0;
      w_carry_d = (i_op == OP_SUB);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_op     <= OP_ADD;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_cout   <= 1'b0;
      r_zero   <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_d;
      r_cnt    <= w_cnt_d;
      r_carry  <= w_carry_d;
      r_op     <= w_op_d;
      r_a_sh   <= w_a_sh_d;
      r_b_sh   <= w_b_sh_d;
      r_acc    <= w_acc_d;
      r_result <= w_result_d;
      r_cout   <= w_cout_d;
      r_zero   <= w_zero_d;
      r_busy   <= (w_state_d == StRun);
      r_done   <= (w_state_d == StDone);
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_result = r_result;
  assign o_cout   = r_cout;
  assign o_zero   = r_zero;

endmodule

// File: tb/tb_sigbin_serial_ctrl.sv
// Directed and randomized checks of the bit-serial sequencer at WIDTH=8.
module tb_sigbin_serial_ctrl;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] AND = 2'b10;
  localparam logic [1:0] OR  = 2'b11;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_start = 1'b0;
  logic [1:0] i_op = 2'b00;
  logic [7:0] i_a = 8'h00;
  logic [7:0] i_b = 8'h00;
  logic       o_busy, o_done, o_cout, o_zero;
  logic [7:0] o_result;

  int total = 0;
  int bad = 0;
  int n_done = 0;

  sigbin_serial_ctrl #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (i_start),
    .i_op     (i_op),
    .i_a      (i_a),
    .i_b      (i_b),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_result (o_result),
    .o_cout   (o_cout),
    .o_zero   (o_zero)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (o_done) n_done++;
    if (!rst) begin
      total++;
      if (o_busy && o_done) begin
        bad++;
        $display("FAIL busy_done_overlap busy=%b done=%b required not both 1", o_busy, o_done);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic start_op(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
    i_op = op; i_a = a; i_b = b; i_start = 1'b1;
    tick();
    i_start = 1'b0;
  endtask

  // lat counts edges from the accepting edge through the edge that raises done.
  task automatic wait_done(output int lat);
    lat = 1;
    for (int k = 0; k < 20; k++) begin
      if (o_done) return;
      tick();
      lat++;
    end
    total++; bad++;
    $display("FAIL done_timeout got no done within 20 cycles");
  endtask

  function automatic logic [9:0] model(input logic [1:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    logic [8:0] s;
    logic [7:0] r;
    logic       c;
    case (op)
      ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; end
      SUB: begin s = {1'b0, a} + {1'b0, ~b} + 9'd1; r = s[7:0]; c = s[8]; end
      AND: begin r = a & b; c = 1'b0; end
      default: begin r = a | b; c = 1'b0; end
    endcase
    return {(r == 8'h00), c, r};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++;
    if ({o_busy, o_done, o_cout, o_zero, o_result} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got busy=%b done=%b cout=%b zero=%b result=%h required all 0",
               o_busy, o_done, o_cout, o_zero, o_result);
    end
    tick();
    total++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      bad++;
      $display("FAIL reset_idle got busy=%b done=%b required 0 0", o_busy, o_done);
    end
  endtask

  task automatic test_add;
    int lat;
    start_op(ADD, 8'hFF, 8'h01);
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL add_busy got %b required 1", o_busy);
    end
    wait_done(lat);
    total++;
    if (lat != 9) begin
      bad++; $display("FAIL add_latency got %0d required 9", lat);
    end
    total++;
    if ({o_result, o_cout, o_zero} !== {8'h00, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL add_ff_01 got result=%h cout=%b zero=%b required 00 1 1",
               o_result, o_cout, o_zero);
    end
    tick();
    total++;
    if (o_done !== 1'b0 || o_busy !== 1'b0 || o_result !== 8'h00) begin
      bad++;
      $display("FAIL add_done_pulse got done=%b busy=%b result=%h required 0 0 00",
               o_done, o_busy, o_result);
    end
  endtask

  task automatic test_sub;
    int lat;
    start_op(SUB, 8'h05, 8'h07);
    wait_done(lat);
    total++;
    if ({o_result, o_cout, o_zero} !== {8'hFE, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL sub_05_07 got result=%h cout=%b zero=%b required fe 0 0",
               o_result, o_cout, o_zero);
    end
    tick();
    start_op(SUB, 8'h07, 8'h05);
    wait_done(lat);
    total++;
    if ({o_result, o_cout, o_zero} !== {8'h02, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL sub_07_05 got result=%h cout=%b zero=%b required 02 1 0",
               o_result, o_cout, o_zero);
    end
    tick();
  endtask

  task automatic test_logic;
    int lat;
    start_op(AND, 8'hF0, 8'h3C);
    wait_done(lat);
    total++;
    if ({o_result, o_cout, o_zero} !== {8'h30, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL and_f0_3c got result=%h cout=%b zero=%b required 30 0 0",
               o_result, o_cout, o_zero);
    end
    tick();
    start_op(OR, 8'hF0, 8'h3C);
    wait_done(lat);
    total++;
    if ({o_result, o_cout, o_zero} !== {8'hFC, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL or_f0_3c got result=%h cout=%b zero=%b required fc 0 0",
               o_result, o_cout, o_zero);
    end
    tick();
  endtask

  task automatic test_ignore_start;
    int lat;
    int n0;
    n0 = n_done;
    start_op(ADD, 8'h10, 8'h20);
    tick(); tick(); tick();
    i_op = SUB; i_a = 8'h55; i_b = 8'h11; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done(lat);
    total++;
    if ({o_result, o_cout, o_zero} !== {8'h30, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL ignore_result got result=%h cout=%b zero=%b required 30 0 0",
               o_result, o_cout, o_zero);
    end
    for (int k = 0; k < 12; k++) tick();
    total++;
    if (n_done - n0 != 1 || o_result !== 8'h30) begin
      bad++;
      $display("FAIL ignore_single_done got dones=%0d result=%h required 1 30",
               n_done - n0, o_result);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    i_op = ADD; i_a = 8'h01; i_b = 8'h02; i_start = 1'b1;
    tick();
    wait_done(lat);
    total++;
    if (lat != 9 || o_result !== 8'h03) begin
      bad++;
      $display("FAIL b2b_first got lat=%0d result=%h required 9 03", lat, o_result);
    end
    i_op = OR; i_a = 8'h0F; i_b = 8'hF0;
    tick();
    i_start = 1'b0;
    total++;
    if (o_busy !== 1'b1 || o_done !== 1'b0 || o_result !== 8'h03) begin
      bad++;
      $display("FAIL b2b_accept got busy=%b done=%b result=%h required 1 0 03",
               o_busy, o_done, o_result);
    end
    wait_done(lat);
    total++;
    if (lat != 9 || {o_result, o_cout, o_zero} !== {8'hFF, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL b2b_second got lat=%0d result=%h cout=%b zero=%b required 9 ff 0 0",
               lat, o_result, o_cout, o_zero);
    end
    tick();
  endtask

  task automatic test_reset_mid_run;
    int lat;
    int n0;
    start_op(ADD, 8'hAA, 8'h55);
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    total++;
    if ({o_busy, o_done, o_cout, o_zero, o_result} !== 12'h000) begin
      bad++;
      $display("FAIL midrun_reset got busy=%b done=%b cout=%b zero=%b result=%h required all 0",
               o_busy, o_done, o_cout, o_zero, o_result);
    end
    rst = 1'b0;
    n0 = n_done;
    for (int k = 0; k < 12; k++) tick();
    total++;
    if (n_done != n0 || o_busy !== 1'b0 || o_result !== 8'h00) begin
      bad++;
      $display("FAIL midrun_no_done got dones=%0d busy=%b result=%h required 0 0 00",
               n_done - n0, o_busy, o_result);
    end
    start_op(ADD, 8'h12, 8'h34);
    wait_done(lat);
    total++;
    if ({o_result, o_cout, o_zero} !== {8'h46, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL after_reset_add got result=%h cout=%b zero=%b required 46 0 0",
               o_result, o_cout, o_zero);
    end
    tick();
  endtask

  task automatic test_sweep;
    int lat;
    logic [7:0] a, b;
    logic [9:0] exp;
    for (int n = 0; n < 200; n++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      if (n == 0) begin a = 8'h00; b = 8'h00; end
      if (n == 1) begin a = 8'h80; b = 8'h80; end
      for (int o = 0; o < 4; o++) begin
        exp = model(2'(o), a, b);
        start_op(2'(o), a, b);
        wait_done(lat);
        total++;
        if (lat != 9 || {o_zero, o_cout, o_result} !== exp) begin
          bad++;
          $display("FAIL sweep op=%0d a=%h b=%h got lat=%0d result=%h cout=%b zero=%b required 9 %h %b %b",
                   o, a, b, lat, o_result, o_cout, o_zero, exp[7:0], exp[8], exp[9]);
        end
        tick();
        total++;
        if (o_done !== 1'b0) begin
          bad++;
          $display("FAIL sweep_done_width got done=%b required 0", o_done);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
